fwd_hazard_unit: RTL and testbench

Parametrised successor to the two-source/two-stage bypass selector. It generates forwarding selects for NUM_SRC EX-stage operands across NUM_STAGES downstream write-back sources, with youngest-wins priority. It also detects load-use hazards and runs a stall FSM that holds the front end for LOAD_LAT cycles. Saturating stall and forward event counters feed performance monitoring. It sits between the ID/EX pipeline register, the later stage registers and the front-end stall/bubble controls.

---
 rtl/fwd_hazard_unit.sv | 171 +++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand bypass select and load-use stall control for the EX stage.
//   - Forwarding: each of NUM_SRC EX operands picks the youngest of
//     NUM_STAGES later stages that writes its register (stage 0 = EX/MEM).
//   - Load-use: a load in EX whose destination is read by the instruction in
//     ID holds the front end for LOAD_LAT cycles (stall + bubble).
//   - Saturating event counters for stall cycles and forwarding cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   ex_src_addr  EX operand register numbers, operand i at [5i+4:5i]
//   ex_src_used  EX operand i is actually read
//   stg_dst      destination register per downstream stage, packed likewise
//   stg_wr       downstream stage k writes a register
//   id_src_addr  ID operand register numbers
//   id_src_used  ID operand i is read
//   ex_dst       destination of the instruction in EX
//   ex_memrd     instruction in EX is a load
//   kill         pipeline flush, aborts any stall in the same cycle
//   clr_stats    synchronous clear of both counters
//   fwd_sel      per-operand select: 0 = register file, k = stage k-1
//   stall        hold PC and IF/ID
//   bubble       insert NOP into ID/EX
//   stall_cnt    cycles with stall asserted (saturating)
//   fwd_cnt      cycles with any nonzero select (saturating)

module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*5-1:0]       ex_src_addr,
  input  logic [NUM_SRC-1:0]         ex_src_used,
  input  logic [NUM_STAGES*5-1:0]    stg_dst,
  input  logic [NUM_STAGES-1:0]      stg_wr,
  input  logic [NUM_SRC*5-1:0]       id_src_addr,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [4:0]                 ex_dst,
  input  logic                       ex_memrd,
  input  logic                       kill,
  input  logic                       clr_stats,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic                       bubble,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           fwd_cnt
);

  // Down-counter only has to hold LOAD_LAT-1.
  localparam int DCNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t              stateReg, stateNext;
  logic [DCNT_W-1:0]   downReg, downNext;
  logic                stallInt;
  logic                hazard;
  logic [NUM_SRC-1:0]  idMatch;
  logic                anyFwd;
  logic [CNT_W-1:0]    stallCntReg, fwdCntReg;

  // ---------------------------------------------------------------------
  // Forwarding selects. Stages are scanned oldest to youngest so that the
  // youngest matching stage is the last assignment and therefore wins.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gSrc
      logic [SEL_W-1:0] srcSel;
      logic [4:0]       srcAddr;

      assign srcAddr = ex_src_addr[gi*5 +: 5];

      always_comb begin
        srcSel = '0;
        if (ex_src_used[gi]) begin
          for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            // r0 is hard-wired zero, never bypass it.
            if (stg_wr[k] && (stg_dst[k*5 +: 5] != 5'd0) &&
                (stg_dst[k*5 +: 5] == srcAddr)) begin
              srcSel = SEL_W'(k + 1);
            end
          end
        end
      end

      assign fwd_sel[gi*SEL_W +: SEL_W] = srcSel;

      assign idMatch[gi] = id_src_used[gi] && (id_src_addr[gi*5 +: 5] == ex_dst);
    end
  endgenerate

  assign anyFwd = |fwd_sel;
  assign hazard = ex_memrd && (ex_dst != 5'd0) && (|idMatch);

  // ---------------------------------------------------------------------
  // Stall FSM. The first stall cycle is raised combinationally from IDLE;
  // STALL covers the remaining LOAD_LAT-1 cycles.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= IDLE;
      downReg  <= '0;
    end else begin
      stateReg <= stateNext;
      downReg  <= downNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    downNext  = downReg;
    stallInt  = 1'b0;
    case (stateReg)
      IDLE: begin
        stallInt = hazard && !kill;
        if (hazard && !kill && (LOAD_LAT > 1)) begin
          stateNext = STALL;
          downNext  = DCNT_W'(LOAD_LAT - 1);
        end
      end
      STALL: begin
        stallInt = !kill;
        if (kill || (downReg == DCNT_W'(1))) begin
          stateNext = IDLE;
          downNext  = '0;
        end else begin
          downNext = downReg - DCNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        downNext  = '0;
      end
    endcase
  end

  // Gate with reset so the combinational IDLE path cannot assert while the
  // unit is held in reset.
  assign stall  = stallInt && rst;
  assign bubble = stallInt && rst;

  // ---------------------------------------------------------------------
  // Saturating statistics counters.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCntReg <= '0;
      fwdCntReg   <= '0;
    end else if (clr_stats) begin
      stallCntReg <= '0;
      fwdCntReg   <= '0;
    end else begin
      if (stallInt && (stallCntReg != '1)) begin
        stallCntReg <= stallCntReg + CNT_W'(1);
      end
      if (anyFwd && (fwdCntReg != '1)) begin
        fwdCntReg <= fwdCntReg + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stallCntReg;
  assign fwd_cnt   = fwdCntReg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Scoreboard bench: the stimulus process drives one cycle of inputs,
//   predicts the outputs with a remaining-stall-cycles model and queues the
//   prediction; the monitor pops one entry per cycle on the falling edge.

module tb_fwd_hazard_unit;

  localparam int NS  = 2;
  localparam int NST = 2;
  localparam int LL  = 3;
  localparam int CW  = 4;
  localparam int SW  = $clog2(NST + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*5-1:0]   exSrcAddr, idSrcAddr;
  logic [NS-1:0]     exSrcUsed, idSrcUsed;
  logic [NST*5-1:0]  stgDst;
  logic [NST-1:0]    stgWr;
  logic [4:0]        exDst;
  logic              exMemrd, kill, clrStats;
  logic [NS*SW-1:0]  fwdSel;
  logic              stall, bubble;
  logic [CW-1:0]     stallCnt, fwdCnt;

  fwd_hazard_unit #(
    .NUM_SRC(NS), .NUM_STAGES(NST), .LOAD_LAT(LL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_src_addr(exSrcAddr), .ex_src_used(exSrcUsed),
    .stg_dst(stgDst), .stg_wr(stgWr),
    .id_src_addr(idSrcAddr), .id_src_used(idSrcUsed),
    .ex_dst(exDst), .ex_memrd(exMemrd), .kill(kill), .clr_stats(clrStats),
    .fwd_sel(fwdSel), .stall(stall), .bubble(bubble),
    .stall_cnt(stallCnt), .fwd_cnt(fwdCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS*SW-1:0] fwd;
    logic             stl;
    logic [CW-1:0]    sc;
    logic [CW-1:0]    fc;
  } exp_t;

  exp_t q[$];
  int   passCnt  = 0;
  int   totalCnt = 0;
  int   cycleNo  = 0;

  // Reference model state
  int stallLeft = 0;
  int mStall    = 0;
  int mFwd      = 0;
  int satMax    = (1 << CW) - 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    totalCnt++;
    if (act === req) passCnt++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cycleNo, act, req);
  endtask

  task automatic predict();
    exp_t e;
    logic anyF;
    logic haz;
    int   sel;
    e    = '0;
    anyF = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sel = 0;
      if (exSrcUsed[i]) begin
        for (int k = 0; k < NST; k++) begin
          if (sel == 0 && stgWr[k] && stgDst[5*k +: 5] != 5'd0 &&
              stgDst[5*k +: 5] == exSrcAddr[5*i +: 5]) sel = k + 1;
        end
      end
      e.fwd[SW*i +: SW] = SW'(sel);
      if (sel != 0) anyF = 1'b1;
    end
    haz = 1'b0;
    for (int i = 0; i < NS; i++)
      if (idSrcUsed[i] && idSrcAddr[5*i +: 5] == exDst) haz = 1'b1;
    haz = haz && exMemrd && (exDst != 5'd0);

    if (!rst) begin
      e.stl = 1'b0; e.sc = '0; e.fc = '0;
      stallLeft = 0; mStall = 0; mFwd = 0;
    end else begin
      if (kill) begin
        e.stl = 1'b0; stallLeft = 0;
      end else if (stallLeft > 0) begin
        e.stl = 1'b1; stallLeft--;
      end else if (haz) begin
        e.stl = 1'b1; stallLeft = LL - 1;
      end else begin
        e.stl = 1'b0;
      end
      e.sc = CW'(mStall);
      e.fc = CW'(mFwd);
      if (clrStats) begin
        mStall = 0; mFwd = 0;
      end else begin
        if (e.stl && mStall < satMax) mStall++;
        if (anyF && mFwd < satMax) mFwd++;
      end
    end
    q.push_back(e);
  endtask

  // Inputs must already be set; predicts this cycle then advances one clock.
  task automatic step();
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b1; exSrcAddr = '0; exSrcUsed = '0; stgDst = '0; stgWr = '0;
    idSrcAddr = '0; idSrcUsed = '0; exDst = '0; exMemrd = 1'b0;
    kill = 1'b0; clrStats = 1'b0;
  endtask

  task automatic hazardIn();
    quiet();
    exMemrd = 1'b1; exDst = 5'd7;
    idSrcAddr = {5'd7, 5'd2}; idSrcUsed = 2'b10;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("fwd_sel",   32'(fwdSel),   32'(e.fwd));
        check("stall",     32'(stall),    32'(e.stl));
        check("bubble",    32'(bubble),   32'(e.stl));
        check("stall_cnt", 32'(stallCnt), 32'(e.sc));
        check("fwd_cnt",   32'(fwdCnt),   32'(e.fc));
        $display("cycle %0d fwd_sel=%0h stall=%0b stall_cnt=%0d fwd_cnt=%0d",
                 cycleNo, fwdSel, stall, stallCnt, fwdCnt);
        cycleNo++;
      end
    end
  end

  // Stimulus
  initial begin
    quiet();
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Reset with a hazard present: outputs must stay low.
    hazardIn(); rst = 1'b0; step();
    quiet(); rst = 1'b0; step();

    // Forwarding priority
    quiet(); exSrcAddr = {5'd5, 5'd5}; exSrcUsed = 2'b11;
    stgDst = {5'd5, 5'd5}; stgWr = 2'b11; step();
    stgWr = 2'b10; step();
    exSrcAddr = {5'd5, 5'd0}; stgDst = {5'd5, 5'd0}; stgWr = 2'b11; step();

    // Unused operand
    quiet(); exSrcAddr = {5'd9, 5'd6}; exSrcUsed = 2'b10;
    stgDst = {5'd9, 5'd6}; stgWr = 2'b11; step();
    exSrcAddr = {5'd4, 5'd6}; step();

    // Load-use stall, then a load to r0
    hazardIn(); step();
    quiet(); repeat (LL + 1) step();
    quiet(); exMemrd = 1'b1; exDst = 5'd0; idSrcUsed = 2'b11; step();
    quiet(); step();

    // Kill on the second stall cycle
    hazardIn(); step();
    hazardIn(); kill = 1'b1; step();
    quiet(); repeat (LL) step();

    // Back-to-back hazard
    hazardIn(); repeat (LL + 1) step();
    quiet(); repeat (LL + 1) step();

    // Saturation then clear during stall
    hazardIn(); repeat (20) step();
    hazardIn(); clrStats = 1'b1; step();
    quiet(); repeat (LL + 1) step();

    // Reset mid-stall
    hazardIn(); step();
    hazardIn(); rst = 1'b0; step();
    quiet(); repeat (3) step();

    // Randomized traffic over a small register range to provoke matches
    for (int n = 0; n < 400; n++) begin
      quiet();
      for (int i = 0; i < NS; i++) begin
        exSrcAddr[5*i +: 5] = 5'($urandom_range(0, 3));
        idSrcAddr[5*i +: 5] = 5'($urandom_range(0, 3));
      end
      for (int k = 0; k < NST; k++) stgDst[5*k +: 5] = 5'($urandom_range(0, 3));
      exSrcUsed = NS'($urandom);
      idSrcUsed = NS'($urandom);
      stgWr     = NST'($urandom);
      exDst     = 5'($urandom_range(0, 3));
      exMemrd   = ($urandom_range(0, 2) == 0);
      kill      = ($urandom_range(0, 11) == 0);
      clrStats  = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 59) != 0);
      step();
    end

    quiet();
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
